// File: rtl/instr_mem_prog.sv
// Run-time loadable instruction memory: fetch port for the PC, streaming load port for the host/DMA.
// Latency: fetch is a registered read, result one cycle after fetch_en; loads write one word per accepted beat.
// Backpressure: wr_ready is high only while loading; wr_valid may stall indefinitely; fetch is blocked during a load.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   address, fetch_en             fetch request from the PC
//   instr_out, instr_valid        fetched word (NOP when nothing valid), valid flag
//   addr_err                      one-cycle pulse for a fetch address >= DEPTH
//   load_start, load_base,        start a load of load_len words at load_base (IDLE only)
//   load_len
//   wr_data, wr_valid, wr_ready   program word stream
//   load_busy, load_done,         load in progress / completed pulse / rejected-or-aborted pulse
//   load_err
//
// DEPTH must not exceed 2**ADDR_W.
module instr_mem_prog #(
  parameter int OPC_W      = 6,
  parameter int OPR_W      = 10,
  parameter int INSTR_W    = OPC_W + OPR_W,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int NOP_OPCODE = 46
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address,
  input  logic               fetch_en,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               addr_err,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic [ADDR_W:0]    load_len,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [INSTR_W-1:0] NOP_WORD = {OPC_W'(NOP_OPCODE), OPR_W'(0)};
  localparam logic [ADDR_W+1:0]  DEPTH_X  = (ADDR_W+2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                wr_ready_q, wr_ready_d;
  logic                load_busy_q, load_busy_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic                instr_valid_q, instr_valid_d;
  logic                addr_err_q, addr_err_d;
  // Selects the RAM read register as the source of instr_out; when clear the
  // output is the NOP word.
  logic                out_ram_q, out_ram_d;

  // Words are stored XOR'ed with the NOP word, so an all-zero power-up array
  // reads back as NOP everywhere without any explicit initialisation pass.
  logic [INSTR_W-1:0]  mem [DEPTH];
  logic [INSTR_W-1:0]  ram_rd_q;

  logic                in_range;
  logic                rd_en;
  logic                wr_en;
  logic [ADDR_W+1:0]   load_end;

  // Widened so that base+len never wraps before the range comparison.
  assign load_end = {2'b00, load_base} + {1'b0, load_len};
  assign in_range = ({2'b00, address} < DEPTH_X);
  assign wr_en    = !rst && (state_q == ST_LOAD) && wr_valid && wr_ready_q;
  assign rd_en    = fetch_en && (state_q != ST_LOAD) && in_range;

  // Load state machine next-state logic.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rem_d      = rem_q;
    load_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (load_len == '0) begin
            state_d = ST_FINISH;
          end else if (load_end > DEPTH_X) begin
            load_err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            wp_d    = load_base;
            rem_d   = load_len;
          end
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          wp_d  = wp_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status outputs are registered copies of the next state so they line up
    // with state_q on the following cycle.
    wr_ready_d  = (state_d == ST_LOAD);
    load_busy_d = (state_d == ST_LOAD);
    load_done_d = (state_d == ST_FINISH);
  end

  // Fetch-side next values.
  always_comb begin
    instr_valid_d = fetch_en && (state_q != ST_LOAD);
    addr_err_d    = fetch_en && !in_range;
    // With fetch_en low both out_ram_q and ram_rd_q hold, so instr_out holds.
    out_ram_d     = fetch_en ? rd_en : out_ram_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wp_q          <= '0;
      rem_q         <= '0;
      wr_ready_q    <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      out_ram_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      rem_q         <= rem_d;
      wr_ready_q    <= wr_ready_d;
      load_busy_q   <= load_busy_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
      out_ram_q     <= out_ram_d;
    end
  end

  // Simple dual-port RAM: one write port, one synchronous read port, no reset
  // so that it maps onto block RAM. Reads never coincide with writes because
  // fetch is blocked while loading.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= wr_data ^ NOP_WORD;
    end
    if (rd_en) begin
      ram_rd_q <= mem[address];
    end
  end

  assign instr_out   = out_ram_q ? (ram_rd_q ^ NOP_WORD) : NOP_WORD;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;
  assign wr_ready    = wr_ready_q;
  assign load_busy   = load_busy_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

endmodule
